// File: rtl/fifo_ctrl.sv
// Control logic for an 8-entry x 8-bit FIFO built around an external register file.
// Holds the read/write pointers, the occupancy count and the sticky overflow/underflow flags.
module fifo_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  output logic       rf_wr_en,
  output logic [2:0] rf_wr_addr,
  output logic [2:0] rf_rd_addr,
  output logic       full,
  output logic       empty,
  output logic [3:0] count,
  output logic       overflow,
  output logic       underflow
);

  logic [2:0] wptr;
  logic [2:0] rptr;
  logic       pop_ok;
  logic       push_ok;

  // Status comes from registered count only, so it never loops back through push/pop.
  assign full  = (count == 4'd8);
  assign empty = (count == 4'd0);

  // A pop frees a slot in the same cycle, which is what lets a push on a full FIFO through.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign rf_wr_en   = push_ok & ~flush & rst_n;
  assign rf_wr_addr = wptr;
  assign rf_rd_addr = rptr;

  // NOTE: register-file contents are deliberately never cleared; empty gates every pop,
  // so stale entries can't be read and the storage needs no reset network.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (!rst_n || flush) begin
      wptr      <= 3'd0;
      rptr      <= 3'd0;
      count     <= 4'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 3'd1;
      if (pop_ok)  rptr <= rptr + 3'd1;
      if (push_ok && !pop_ok)      count <= count + 4'd1;
      else if (pop_ok && !push_ok) count <= count - 4'd1;
      if (push && full && !pop_ok) overflow  <= 1'b1;
      if (pop && empty)            underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model with a local register file.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic       flush;
  logic [7:0] wdata;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [2:0] rf_rd_addr;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_writes = 0;

  fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .rf_wr_en  (rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_rd_addr(rf_rd_addr),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file the controller drives; head data is a combinational read.
  logic [7:0] rf_mem [8];
  logic [7:0] head;
  assign head = rf_mem[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= wdata;
      n_writes <= n_writes + 1;
    end
  end

  // Reference model: contents as a queue, addresses as accepted-operation counts mod 8.
  logic [7:0] mq[$];
  int  m_pushes = 0;
  int  m_pops   = 0;
  bit  m_ov     = 0;
  bit  m_uf     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the active edge, then let combinational outputs settle.
  task automatic apply(input logic r, input logic f, input logic pu, input logic po,
                       input logic [7:0] d);
    @(negedge clk);
    rst_n = r; flush = f; push = pu; pop = po; wdata = d;
    #1;
  endtask

  // Advance one edge, update the model from the applied inputs, then return inputs to idle.
  task automatic tick();
    bit pop_acc, push_acc;
    @(posedge clk);
    if (!rst_n || flush) begin
      mq.delete();
      m_pushes = 0; m_pops = 0; m_ov = 0; m_uf = 0;
    end else begin
      pop_acc  = pop && (mq.size() > 0);
      push_acc = push && ((mq.size() < 8) || pop_acc);
      if (pop && mq.size() == 0) m_uf = 1;
      if (push && !push_acc)     m_ov = 1;
      if (pop_acc)  begin void'(mq.pop_front()); m_pops++; end
      if (push_acc) begin mq.push_back(wdata); m_pushes++; end
    end
    #1;
    rst_n = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    bit exp_pop_ok, exp_push_ok, exp_we;
    exp_pop_ok  = pop && (mq.size() > 0);
    exp_push_ok = push && ((mq.size() < 8) || exp_pop_ok);
    exp_we      = rst_n && !flush && exp_push_ok;
    check({tag, ".wr_en"},     32'(rf_wr_en),   32'(exp_we));
    check({tag, ".wr_addr"},   32'(rf_wr_addr), 32'(m_pushes % 8));
    check({tag, ".rd_addr"},   32'(rf_rd_addr), 32'(m_pops % 8));
    check({tag, ".count"},     32'(count),      32'(mq.size()));
    check({tag, ".full"},      32'(full),       32'(mq.size() == 8));
    check({tag, ".empty"},     32'(empty),      32'(mq.size() == 0));
    check({tag, ".overflow"},  32'(overflow),   32'(m_ov));
    check({tag, ".underflow"}, 32'(underflow),  32'(m_uf));
    if (mq.size() > 0) check({tag, ".head"}, 32'(head), 32'(mq[0]));
  endtask

  task automatic cyc(input string tag, input logic r, input logic f, input logic pu,
                     input logic po, input logic [7:0] d);
    apply(r, f, pu, po, d);
    compare_model(tag);
    tick();
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'hee);
    check("reset.wr_en_low", 32'(rf_wr_en), 32'd0);
    tick();
  endtask

  typedef struct {
    logic       pu, po;
    logic [7:0] d;
    logic       we;
    logic [2:0] wa, ra;
    logic [3:0] cnt;
    logic       fu, em, ov, uf;
    logic       chk_head;
    logic [7:0] hd;
  } vec_t;

  vec_t tbl[20];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int wr_seen;
    logic [7:0] old_head;

    // Fill 8, reject a 9th push, drain 8, reject a 9th pop (pre-edge outputs per cycle).
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 8'(8'h10 + i), 1'b1, 3'(i), 3'd0, 4'(i),
                 1'b0, (i == 0), 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[8] = '{1'b1, 1'b0, 8'h99, 1'b0, 3'd0, 3'd0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10};
    for (int j = 0; j < 8; j++)
      tbl[10 + j] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 3'(j), 4'(8 - j),
                      (j == 0), 1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h10 + j)};
    tbl[18] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; wdata = 8'h00;
    do_reset();
    do_reset();
    check("reset.count", 32'(count), 32'd0);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full",  32'(full),  32'd0);
    check("reset.wr_addr", 32'(rf_wr_addr), 32'd0);
    check("reset.rd_addr", 32'(rf_rd_addr), 32'd0);
    check("reset.flags", 32'({overflow, underflow}), 32'd0);

    for (int k = 0; k < 20; k++) begin
      apply(1'b1, 1'b0, tbl[k].pu, tbl[k].po, tbl[k].d);
      check($sformatf("vec%0d.wr_en", k),   32'(rf_wr_en),   32'(tbl[k].we));
      check($sformatf("vec%0d.wr_addr", k), 32'(rf_wr_addr), 32'(tbl[k].wa));
      check($sformatf("vec%0d.rd_addr", k), 32'(rf_rd_addr), 32'(tbl[k].ra));
      check($sformatf("vec%0d.count", k),   32'(count),      32'(tbl[k].cnt));
      check($sformatf("vec%0d.full", k),    32'(full),       32'(tbl[k].fu));
      check($sformatf("vec%0d.empty", k),   32'(empty),      32'(tbl[k].em));
      check($sformatf("vec%0d.ovf", k),     32'(overflow),   32'(tbl[k].ov));
      check($sformatf("vec%0d.udf", k),     32'(underflow),  32'(tbl[k].uf));
      if (tbl[k].chk_head) check($sformatf("vec%0d.head", k), 32'(head), 32'(tbl[k].hd));
      tick();
    end

    // Wrap: push 6, pop 6, push 4 -> write addresses 6,7,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) cyc("wrap.push", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 6; i++) cyc("wrap.pop",  1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
      check($sformatf("wrap.addr%0d", i), 32'(rf_wr_addr), 32'((6 + i) % 8));
      compare_model("wrap.push2");
      tick();
    end
    check("wrap.rd_addr", 32'(rf_rd_addr), 32'd6);
    check("wrap.count",   32'(count),      32'd4);

    // Simultaneous push+pop on empty: push accepted, pop rejected, no fall-through.
    do_reset();
    apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h5a);
    check("simul_empty.wr_en", 32'(rf_wr_en), 32'd1);
    tick();
    check("simul_empty.count", 32'(count),     32'd1);
    check("simul_empty.udf",   32'(underflow), 32'd1);
    check("simul_empty.empty", 32'(empty),     32'd0);
    check("simul_empty.head",  32'(head),      32'h5a);

    // Simultaneous push+pop on full: both accepted, head is the old entry.
    do_reset();
    for (int i = 0; i < 8; i++) cyc("simul_full.fill", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    apply(1'b1, 1'b0, 1'b1, 1'b1, 8'haa);
    old_head = head;
    check("simul_full.old_head", 32'(old_head), 32'h20);
    check("simul_full.wr_en",    32'(rf_wr_en), 32'd1);
    tick();
    check("simul_full.count",   32'(count),      32'd8);
    check("simul_full.wr_addr", 32'(rf_wr_addr), 32'd1);
    check("simul_full.rd_addr", 32'(rf_rd_addr), 32'd1);
    check("simul_full.ovf",     32'(overflow),   32'd0);
    check("simul_full.head",    32'(head),       32'h21);

    // Flush, then reset, each with count 5 and overflow set, and a push in the clear cycle.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 9; i++) cyc("clr.fill", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
      for (int i = 0; i < 3; i++) cyc("clr.pop",  1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("clr%0d.pre_count", pass), 32'(count),    32'd5);
      check($sformatf("clr%0d.pre_ovf", pass),   32'(overflow), 32'd1);
      if (pass == 0) apply(1'b1, 1'b1, 1'b1, 1'b0, 8'hcc);
      else           apply(1'b0, 1'b0, 1'b1, 1'b0, 8'hcc);
      wr_seen = n_writes;
      check($sformatf("clr%0d.wr_en", pass), 32'(rf_wr_en), 32'd0);
      tick();
      check($sformatf("clr%0d.no_write", pass), 32'(n_writes), 32'(wr_seen));
      check($sformatf("clr%0d.count", pass),    32'(count),    32'd0);
      check($sformatf("clr%0d.empty", pass),    32'(empty),    32'd1);
      check($sformatf("clr%0d.ovf", pass),      32'(overflow), 32'd0);
      apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
      check($sformatf("clr%0d.first_addr", pass), 32'(rf_wr_addr), 32'd0);
      check($sformatf("clr%0d.first_we", pass),   32'(rf_wr_en),   32'd1);
      tick();
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, f, pu, po;
      r  = ($urandom_range(0, 99) != 0);
      f  = ($urandom_range(0, 49) == 0);
      pu = ($urandom_range(0, 99) < ((n / 500) % 2 ? 35 : 65));
      po = ($urandom_range(0, 99) < ((n / 500) % 2 ? 65 : 35));
      cyc("rand", r, f, pu, po, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameters: none; the block is fixed to an 8-entry x 8-bit register file with 3-bit addresses.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 push  input  1  request to write one entry this cycle.
REQ-005 pop  input  1  request to retire the head entry this cycle.
REQ-006 flush  input  1  synchronous clear of all FIFO state.
REQ-007 rf_wr_en  output  1  write enable to register file.
REQ-008 rf_wr_addr  output  3  write address to register file (= write pointer).
REQ-009 rf_rd_addr  output  3  read address to register file (= read pointer); the register file supplies head data combinationally.
REQ-010 full  output  1  high when count == 8.
REQ-011 empty  output  1  high when count == 0.
REQ-012 count  output  4  number of stored entries, 0..8.
REQ-013 overflow  output  1  sticky flag: a push was rejected.
REQ-014 underflow  output  1  sticky flag: a pop was rejected.

Function
REQ-015 State: wptr[2:0], rptr[2:0], count[3:0], overflow, underflow; all registered, all updated only on a clk rising edge.
REQ-016 The block shall compute pop_ok = pop & ~empty.
REQ-017 The block shall compute push_ok = push & (~full | pop_ok); push while full is accepted only together with an accepted pop.
REQ-018 rf_wr_en = push_ok & ~flush, combinational; rf_wr_addr = wptr; rf_rd_addr = rptr.
REQ-019 On push_ok, wptr increments by 1 modulo 8 (7 -> 0 wrap).
REQ-020 On pop_ok, rptr increments by 1 modulo 8 (7 -> 0 wrap).
REQ-021 count next value: +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither occur.
REQ-022 Push and pop together on empty: pop is rejected (no fall-through), push is accepted, count becomes 1, and underflow is set.
REQ-023 Push and pop together on full: both are accepted, count stays 8, and head data read in that cycle is the old entry (the write lands at the edge).
REQ-024 full and empty are decoded combinationally from registered count only; they never depend on push or pop in the same cycle.
REQ-025 overflow is set when push & full & ~pop_ok and held until reset or flush.
REQ-026 underflow is set when pop & empty and held until reset or flush.
REQ-027 flush (with rst_n high) clears wptr, rptr, count, overflow and underflow to 0 at the next edge; push and pop in that cycle are ignored and rf_wr_en is held low.
REQ-028 Latency: an entry pushed in cycle N is visible at rf_rd_addr/head in cycle N+1 when the FIFO was empty; empty deasserts in cycle N+1.
REQ-029 Register file contents are not cleared by reset or flush; stale data shall never be reported because empty gates pops.

Reset
REQ-030 When rst_n is low at a rising edge, wptr = 0, rptr = 0, count = 0, overflow = 0 and underflow = 0; therefore full = 0, empty = 1, rf_wr_addr = 0 and rf_rd_addr = 0.
REQ-031 Reset has priority over flush, push and pop; rf_wr_en shall be 0 in any cycle where rst_n is low.
REQ-032 Reset asserted mid-operation (for example, count = 5) discards all entries; the first push after reset writes address 0.

Verification
REQ-033 Fill: after reset, 8 consecutive pushes with data 0x10..0x17 -> rf_wr_addr 0..7, count 8, full = 1, overflow = 0; a 9th push -> rf_wr_en = 0, count 8, overflow = 1.
REQ-034 Drain: from full, 8 pops -> head data reads 0x10..0x17 in order, empty = 1 after the 8th pop; a 9th pop -> count 0, underflow = 1.
REQ-035 Wrap: push 6, pop 6, push 4 -> rf_wr_addr sequence 6, 7, 0, 1, rptr = 6, count 4.
REQ-036 Simultaneous: on full, push + pop -> count stays 8, popped value equals the old head, and wptr and rptr both advance; on empty, push + pop -> count 1, underflow = 1.
REQ-037 Flush/reset: with count = 5 and overflow = 1, assert flush together with push -> next cycle count 0, empty = 1, overflow = 0, and no write occurs; repeat the same test with rst_n low in place of flush -> same result.
